// File: rtl/sub_sat_stage.sv
// sub_sat_stage: two-stage valid/ready pipeline around a signed subtractor
// with optional saturation, sticky overflow flag and overflow event counter.
//
// Ports:
//   clk_i, rst_i (sync, active-high)
//   in_valid_i/in_ready_o, a_i, b_i, ci_i, sat_i   operand side
//   out_valid_o/out_ready_i, s_o, v_o, sat_o       result side
//   clr_i, ovf_sticky_o, ovf_cnt_o                 overflow statistics

module sub_v #(
  parameter int WIDTH = 8,
  parameter int SPEED = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  output logic [WIDTH-1:0] s_o,
  output logic             v_o
);

  generate
    if (SPEED == 0) begin : g_serial
      // Ripple-borrow chain, one bit per step.
      logic [WIDTH:0] bw;
      always_comb begin
        s_o   = '0;
        bw    = '0;
        bw[0] = ci_i;
        for (int i = 0; i < WIDTH; i++) begin
          s_o[i]  = a_i[i] ^ b_i[i] ^ bw[i];
          bw[i+1] = (~a_i[i] & b_i[i])
                  | (~(a_i[i] ^ b_i[i]) & bw[i]);
        end
      end
    end else begin : g_prefix
      // Parallel-prefix forms are left to the
      // synthesis carry-chain mapping.
      assign s_o = a_i - b_i
                 - {{(WIDTH-1){1'b0}}, ci_i};
    end
  endgenerate

  // Signs of operands differ and result sign
  // differs from the minuend.
  assign v_o = (a_i[WIDTH-1] ^ b_i[WIDTH-1])
             & (s_o[WIDTH-1] ^ a_i[WIDTH-1]);

endmodule

module sub_sat_stage #(
  parameter int WIDTH     = 8,
  parameter int SPEED     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 ci_i,
  input  logic                 sat_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     s_o,
  output logic                 v_o,
  output logic                 sat_o,
  input  logic                 clr_i,
  output logic                 ovf_sticky_o,
  output logic [CNT_WIDTH-1:0] ovf_cnt_o
);

  localparam logic [WIDTH-1:0] SMAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CMAX =
    {CNT_WIDTH{1'b1}};

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_a_q, s1_a_d;
  logic [WIDTH-1:0]     s1_b_q, s1_b_d;
  logic                 s1_ci_q, s1_ci_d;
  logic                 s1_sat_q, s1_sat_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]     s2_s_q, s2_s_d;
  logic                 s2_v_q, s2_v_d;
  logic                 s2_sat_q, s2_sat_d;
  logic                 sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic             s2_free;
  logic             s1_move;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] sub_s;
  logic             sub_v_flag;

  sub_v #(
    .WIDTH (WIDTH),
    .SPEED (SPEED)
  ) u_sub (
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .ci_i (s1_ci_q),
    .s_o  (sub_s),
    .v_o  (sub_v_flag)
  );

  assign s2_free    = !s2_valid_q | out_ready_i;
  assign in_ready_o = !s1_valid_q | s2_free;
  assign s1_move    = s1_valid_q & s2_free;
  assign in_xfer    = in_valid_i & in_ready_o;
  assign out_xfer   = s2_valid_q & out_ready_i;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_ci_d    = s1_ci_q;
    s1_sat_d   = s1_sat_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a_i;
      s1_b_d     = b_i;
      s1_ci_d    = ci_i;
      s1_sat_d   = sat_i;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_s_d     = s2_s_q;
    s2_v_d     = s2_v_q;
    s2_sat_d   = s2_sat_q;
    if (s1_move) begin
      s2_valid_d = 1'b1;
      s2_v_d     = sub_v_flag;
      s2_sat_d   = sub_v_flag & s1_sat_q;
      if (sub_v_flag & s1_sat_q) begin
        s2_s_d = s1_a_q[WIDTH-1] ? SMIN : SMAX;
      end else begin
        s2_s_d = sub_s;
      end
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end
  end

  // A clear coinciding with an overflow delivery
  // restarts the count at that event.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
    if (out_xfer & s2_v_q) begin
      sticky_d = 1'b1;
      if (cnt_d != CMAX) begin
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ci_q    <= 1'b0;
      s1_sat_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_s_q     <= '0;
      s2_v_q     <= 1'b0;
      s2_sat_q   <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_ci_q    <= s1_ci_d;
      s1_sat_q   <= s1_sat_d;
      s2_valid_q <= s2_valid_d;
      s2_s_q     <= s2_s_d;
      s2_v_q     <= s2_v_d;
      s2_sat_q   <= s2_sat_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid_o  = s2_valid_q;
  assign s_o          = s2_s_q;
  assign v_o          = s2_v_q;
  assign sat_o        = s2_sat_q;
  assign ovf_sticky_o = sticky_q;
  assign ovf_cnt_o    = cnt_q;

endmodule
